// File: rtl/multi_timer.sv
// multi_timer: CHANNELS prescaled up-counters with compare match, periodic/one-shot modes and sticky irq.
// Define MULTI_TIMER_CHAIN_EN to let channel k>=1 count the match/wrap events of channel k-1.
module multi_timer #(
    parameter int CHANNELS        = 4,
    parameter int WIDTH           = 32,
    parameter int PRESCALER_WIDTH = 9,
    localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chipSelect,
    input  logic                write,
    input  logic                writeCommand,
    input  logic [CH_W-1:0]     channel,
    input  logic                regSelect,
    input  logic [31:0]         dataIn,
    output logic [31:0]         dataOut,
    output logic [CHANNELS-1:0] irq
);

    localparam logic [2:0] OP_DIV   = 3'd1;
    localparam logic [2:0] OP_START = 3'd2;
    localparam logic [2:0] OP_STOP  = 3'd3;
    localparam logic [2:0] OP_CLEAR = 3'd4;

    logic [CHANNELS-1:0][WIDTH-1:0]           counter_q, counter_d;
    logic [CHANNELS-1:0][WIDTH-1:0]           compare_q, compare_d;
    logic [CHANNELS-1:0][PRESCALER_WIDTH-1:0] divider_q, divider_d;
    logic [CHANNELS-1:0][PRESCALER_WIDTH-1:0] divide_by_q, divide_by_d;
    logic [CHANNELS-1:0]                      running_q, running_d;
    logic [CHANNELS-1:0]                      one_shot_q, one_shot_d;
    logic [CHANNELS-1:0]                      pending_q, pending_d;
    logic [CHANNELS-1:0]                      overflow_q, overflow_d;
    logic [CHANNELS-1:0]                      chained_w;
    logic [2:0]                               opcode;

    assign opcode = dataIn[2:0];
    assign irq    = pending_q;

`ifdef MULTI_TIMER_CHAIN_EN
    logic [CHANNELS-1:0] chained_q, chained_d;
    assign chained_w = chained_q;
`else
    assign chained_w = '0;
`endif

    always_comb begin
        logic                       sel, cmd, wr, chain_mode, div_tick, tick, wrap, hit, ev, prev_ev;
        logic [PRESCALER_WIDTH-1:0] div_last;
        logic [WIDTH-1:0]           nxt;

        counter_d   = counter_q;
        compare_d   = compare_q;
        divider_d   = divider_q;
        divide_by_d = divide_by_q;
        running_d   = running_q;
        one_shot_d  = one_shot_q;
        pending_d   = pending_q;
        overflow_d  = overflow_q;
`ifdef MULTI_TIMER_CHAIN_EN
        chained_d   = chained_q;
`endif
        sel = 1'b0; cmd = 1'b0; wr = 1'b0; chain_mode = 1'b0; div_tick = 1'b0;
        tick = 1'b0; wrap = 1'b0; hit = 1'b0; ev = 1'b0; prev_ev = 1'b0;
        div_last = '0;
        nxt = '0;

        for (int k = 0; k < CHANNELS; k++) begin
            sel = (channel == CH_W'(k));
            cmd = sel && chipSelect && writeCommand;
            wr  = sel && chipSelect && write && !writeCommand;
`ifdef MULTI_TIMER_CHAIN_EN
            chain_mode = (k != 0) && chained_q[k];
`else
            chain_mode = 1'b0;
`endif
            // divideBy of 0 acts as 1; >= also recovers if divideBy shrinks below the divider
            div_last = (divide_by_q[k] == '0) ? '0 : divide_by_q[k] - PRESCALER_WIDTH'(1);
            div_tick = (divider_q[k] >= div_last);
            if (running_q[k] && !chain_mode)
                divider_d[k] = div_tick ? '0 : divider_q[k] + PRESCALER_WIDTH'(1);

            tick = running_q[k] && (chain_mode ? prev_ev : div_tick)
                   && !(cmd && opcode == OP_STOP) && !(wr && !regSelect);
            nxt  = counter_q[k] + WIDTH'(1);
            wrap = (counter_q[k] == '1);
            hit  = (nxt == compare_q[k]);
            ev   = tick && (wrap || hit);

            if (tick) begin
                if (wrap)
                    overflow_d[k] = 1'b1;
                if (hit) begin
                    pending_d[k] = 1'b1;
                    if (one_shot_q[k]) begin
                        counter_d[k] = compare_q[k];
                        running_d[k] = 1'b0;
                    end else begin
                        counter_d[k] = '0;
                    end
                end else begin
                    counter_d[k] = nxt;
                end
            end
            prev_ev = ev;

            if (wr) begin
                if (regSelect)
                    compare_d[k] = dataIn[WIDTH-1:0];
                else
                    counter_d[k] = dataIn[WIDTH-1:0];
            end

            // commands are applied last so clear and stop override same-cycle tick results
            if (cmd) begin
                case (opcode)
                    OP_DIV:   divide_by_d[k] = dataIn[PRESCALER_WIDTH+2:3];
                    OP_START: begin
                        running_d[k]  = 1'b1;
                        divider_d[k]  = '0;
                        one_shot_d[k] = dataIn[3];
`ifdef MULTI_TIMER_CHAIN_EN
                        chained_d[k]  = dataIn[4];
`endif
                    end
                    OP_STOP:  running_d[k] = 1'b0;
                    OP_CLEAR: begin
                        pending_d[k]  = 1'b0;
                        overflow_d[k] = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter_q   <= '0;
            compare_q   <= '0;
            divider_q   <= '0;
            divide_by_q <= '0;
            running_q   <= '0;
            one_shot_q  <= '0;
            pending_q   <= '0;
            overflow_q  <= '0;
        end else begin
            counter_q   <= counter_d;
            compare_q   <= compare_d;
            divider_q   <= divider_d;
            divide_by_q <= divide_by_d;
            running_q   <= running_d;
            one_shot_q  <= one_shot_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef MULTI_TIMER_CHAIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            chained_q <= '0;
        else
            chained_q <= chained_d;
    end
`endif

    always_comb begin
        dataOut = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (reset && channel == CH_W'(k)) begin
                if (!regSelect) begin
                    dataOut = 32'(counter_q[k]);
                end else begin
                    dataOut[0] = running_q[k];
                    dataOut[1] = one_shot_q[k];
                    dataOut[2] = pending_q[k];
                    dataOut[3] = overflow_q[k];
                    dataOut[4] = chained_w[k];
                    dataOut[16 +: PRESCALER_WIDTH] = divide_by_q[k];
                end
            end
        end
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel successor to the single-channel bus timer, sitting on the same chip-select peripheral bus. Provides `CHANNELS` independent up-counters, each with its own prescaler, compare register, periodic/one-shot mode and sticky interrupt flag. Software programs channels through command and data writes and reads back counters or status combinationally. An optional cascade mode lets a channel count the events of its lower neighbour.

## Interface
- `CHANNELS`, 4: number of timer channels; range 1–16.
- `WIDTH`, 32: counter and compare width; range 8–32; `dataIn`/`dataOut` stay 32 bits.
- `PRESCALER_WIDTH`, 9: width of the per-channel `divideBy` register; range 1–16.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `chipSelect` in 1: qualifies `write` and `writeCommand`.
- `write` in 1: data write to the register chosen by `regSelect`.
- `writeCommand` in 1: command write; `dataIn[2:0]` is the opcode.
- `channel` in max(1,$clog2(CHANNELS)): target channel for writes and reads.
- `regSelect` in 1: 0 selects counter, 1 selects compare (write) or status (read).
- `dataIn` in 32: write data or command word.
- `dataOut` out 32: combinational readback of the selected channel.
- `irq` out CHANNELS: registered per-channel pending flags.

## Operation
- Command opcodes (`chipSelect & writeCommand`; wins over `write` if both high):
  - 000: NOP.
  - 001: `divideBy <= dataIn[PRESCALER_WIDTH+2:3]`.
  - 010: start. Sets `running=1`, `divider<=0`, `oneShot<=dataIn[3]`, `chained<=dataIn[4]`.
  - 011: stop. Sets `running=0`; counter is held.
  - 100: clear pending and overflow flags.
  - 101–111: ignored.
- Data write (`chipSelect & write & !writeCommand`): `regSelect=0` writes `counter <= dataIn[WIDTH-1:0]`; `regSelect=1` writes `compare`. A data write never raises a match.
- Prescaler, per running non-chained channel:
  - `divider` counts 0..`divideBy`-1, then wraps to 0 and emits a one-cycle tick.
  - `divideBy` of 0 behaves as 1, giving a tick every cycle.
- On tick, `next = counter+1` modulo 2^WIDTH.
  - Wrap from all-ones to 0 sets sticky `overflow`.
  - If `next == compare`, `pending` is set. Periodic mode then loads `counter <= 0`. One-shot mode loads `counter <= compare` and clears `running`.
  - Otherwise `counter <= next`.
- Collisions in the same cycle:
  - Counter data write beats tick; the divider keeps running.
  - Clear command beats a new match; the match is lost.
  - Stop beats a tick.
  - A compare write applies to the next tick.
- Read mux:
  - `regSelect=0`: zero-extended counter.
  - `regSelect=1`: status. bit0 `running`, bit1 `oneShot`, bit2 `pending`, bit3 `overflow`, bit4 `chained`, bits[PRESCALER_WIDTH+15:16] `divideBy`, other bits 0.
- `channel` values ≥ CHANNELS: writes are ignored and reads return 0.

## Timing
- Reset values are 0 for all counters, compares, dividers, `divideBy` and flags; `irq=0`. `dataOut` shows 0 while in reset.
- Writes and commands take effect at the rising edge on which they are sampled.
- `counter` first increments `divideBy` cycles after the start edge. Example: `divideBy=0x80` gives counter=1 after 128 edges.
- `irq[k]` equals `pending[k]`. It rises at the edge that performs the match and stays high until a clear command or reset.
- `dataOut` is combinational from `channel`, `regSelect` and current state, with zero latency.
- Asserting reset mid-count clears state immediately without waiting for a clock edge. The block counts again only after a new start command.

## Configuration
- `MULTI_TIMER_CHAIN_EN` defined:
  - A channel k≥1 with `chained=1` bypasses its prescaler.
  - It ticks on every cycle in which channel k-1 produces a match or wrap event.
  - It must still be running to count.
  - Channel 0 ignores `chained`.
- Not defined: `dataIn[4]` on start is ignored, `chained` reads as 0, and no chaining logic is built.

## Test plan
- Set `divideBy=0x80` on ch0, start periodic, hold 127 cycles -> `divider` steps 0..126 and the counter stays 0. On the 128th edge -> counter=1 and divider=0.
- Ch1: `divideBy=1`, `compare=3`, start periodic -> counter goes 1,2, then 0 with `irq[1]=1`. After 3 more cycles it matches again and `irq[1]` stays 1. Clear command -> `irq[1]=0`.
- Ch2: `divideBy=1`, `compare=5`, start one-shot -> counter holds 5, `running=0` and `irq[2]=1`. Further cycles leave counter=5.
- Ch0 counter write `0xFFFFFFFE` with `compare=0x10` and `divideBy=1` running -> counter goes `0xFFFFFFFF`, then 0 with status bit3=1 and no irq.
- Counter write `0x1234` in the same cycle as a tick -> counter=0x1234. Clear command and match in the same cycle -> `pending=0`.
- With `MULTI_TIMER_CHAIN_EN`: ch0 `divideBy=1`, `compare=4` periodic; ch1 chained -> ch1 increments once every 4 cycles. Drop `reset` mid-run -> all counters, `irq` and `dataOut` are 0 immediately.
